conv3x3_edge_filter: RTL and testbench
======================================

Name: conv3x3_edge_filter

Overview:
Parametrised 3x3 gradient edge filter; successor to the fixed Sobel/threshold convolution stage in the image-processing kernel path. Takes one 3x3 pixel window per AXI-stream beat from the line-buffer/window block and emits one output pixel per accepted window. Adds the following over the previous generation:
- pixel-width generalisation
- runtime kernel select (Sobel/Prewitt)
- runtime output mode (binary threshold or saturated L1 magnitude)
- runtime threshold
- full downstream backpressure

Parameters:
P_PIXEL_WIDTH, 8, unsigned pixel width W (4..12)
P_THRESHOLD_WIDTH, 2*P_PIXEL_WIDTH+6, width of squared-magnitude compare
P_THRESHOLD_RESET, 5000, i_threshold value the integrating top ties off by default (documentation only)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  slave AXI-stream valid
i_data  in  9*W  window; pixel k (row-major, k=0 top-left) at bits [W*k +: W], unsigned
o_ready  out  1  slave AXI-stream ready
i_kernel_sel  in  1  0=Sobel, 1=Prewitt; sampled with each accepted beat
i_out_mode  in  1  0=binary threshold, 1=L1 magnitude; sampled with each accepted beat
i_threshold  in  P_THRESHOLD_WIDTH  unsigned; sampled with each accepted beat
i_ready  in  1  master AXI-stream ready
o_data  out  W  output pixel
o_valid  out  1  master AXI-stream valid

Behaviour:
- Reset: asynchronous, active-high. Clears all stage valids, o_valid=0, o_data=0. o_ready=1 after reset release. Pipeline data registers are also cleared.
- Reset mid-stream: in-flight beats are discarded. o_valid falls in the same instant as i_reset. No stale beat emerges after release.
- Pipeline: 4 stages, one global advance enable: en = !v4 || i_ready. o_ready = en (combinational from i_ready, by design).
- Accept: a beat is accepted when i_valid && o_ready. Its config (kernel_sel, out_mode, threshold) travels with the beat through every stage. Config changes therefore never corrupt in-flight beats.
- Latency: 4 cycles from acceptance to o_valid with no stall. Throughput is 1 beat/cycle.
- While en=0, all stages hold and o_data/o_valid stay stable (AXI rule: valid never drops without i_ready).
- S1 (multiply): per tap, signed coef × {1'b0,pixel}, width W+3 signed.
  - Sobel Gx = [1,0,-1, 2,0,-2, 1,0,-1]; Gy = [1,2,1, 0,0,0, -1,-2,-1].
  - Prewitt Gx = [1,0,-1, 1,0,-1, 1,0,-1]; Gy = [1,1,1, 0,0,0, -1,-1,-1].
- S2 (sum): 9-input signed adder tree per axis; gx, gy of width W+4 signed. No overflow possible.
- S3: compute sq = gx² + gy² (2W+6 unsigned) and l1 = |gx| + |gy| (W+4 unsigned).
- S4 (output):
  - out_mode=0: o_data = all-ones if sq > threshold (strict), else 0.
  - out_mode=1: o_data = min(l1, 2^W-1).
- Bubbles (stage valid=0) advance freely; data registers may load when their valid is 0.

Decomposition:
- Package conv3x3_pkg holds:
  - kernel_e enum {KERNEL_SOBEL, KERNEL_PREWITT}
  - out_mode_e enum {OUT_BINARY, OUT_MAGNITUDE}
  - localparam coefficient arrays SOBEL_X/Y, PREWITT_X/Y (signed 3-bit)
  - width functions for product, sum and square given W
- One sub-module, conv3x3_adder_tree: parametrised signed 9-input sum, registered output. It is instantiated twice (Gx, Gy) for S2.

Test Plan:
- Sobel, out_mode=0, threshold=5000, W=8, left column 0 / middle 0 / right column 255 (p2,p5,p8=255) -> gx=-1020, gy=0, sq=1040400 -> o_data=0xFF, 4 cycles after acceptance.
- Uniform window all 100, Sobel, both out modes -> o_data=0x00.
- Prewitt, same edge window, threshold=585225 -> o_data=0x00; threshold=585224 -> 0xFF. Verifies the strict compare.
- Sobel, out_mode=1, only p2=10 -> gx=-10, gy=10 -> o_data=20. Edge window -> l1=1020 saturates to 0xFF.
- Stream 8 back-to-back beats with alternating kernel_sel/out_mode, i_ready low for 3 cycles mid-stream -> all 8 outputs in order, each using its own config. o_valid/o_data stable while stalled; o_ready=0 only while stage 4 is full and i_ready=0.
- Assert i_reset asynchronously with 3 beats in flight -> o_valid=0 immediately. After release o_ready=1 and no output appears until a new beat has been accepted 4 cycles earlier.

Source files
------------

// File: rtl/conv3x3_pkg.sv
// Shared types, gradient coefficient tables and width helpers for the
// 3x3 gradient edge filter.
package conv3x3_pkg;

   localparam int N_TAPS = 9;

   typedef enum logic {
      KERNEL_SOBEL   = 1'b0,
      KERNEL_PREWITT = 1'b1
   } kernel_e;

   typedef enum logic {
      OUT_BINARY    = 1'b0,
      OUT_MAGNITUDE = 1'b1
   } out_mode_e;

   typedef logic signed [2:0] coef_t;

   // Taps are row-major, index 0 is the top-left pixel of the window.
   localparam coef_t SOBEL_X   [N_TAPS] = '{ 3'sd1,  3'sd0, -3'sd1,
                                             3'sd2,  3'sd0, -3'sd2,
                                             3'sd1,  3'sd0, -3'sd1 };
   localparam coef_t SOBEL_Y   [N_TAPS] = '{ 3'sd1,  3'sd2,  3'sd1,
                                             3'sd0,  3'sd0,  3'sd0,
                                            -3'sd1, -3'sd2, -3'sd1 };
   localparam coef_t PREWITT_X [N_TAPS] = '{ 3'sd1,  3'sd0, -3'sd1,
                                             3'sd1,  3'sd0, -3'sd1,
                                             3'sd1,  3'sd0, -3'sd1 };
   localparam coef_t PREWITT_Y [N_TAPS] = '{ 3'sd1,  3'sd1,  3'sd1,
                                             3'sd0,  3'sd0,  3'sd0,
                                            -3'sd1, -3'sd1, -3'sd1 };

   function automatic int prod_width(input int w);
      return w + 3;
   endfunction

   function automatic int sum_width(input int w);
      return w + 4;
   endfunction

   function automatic int sq_width(input int w);
      return 2 * w + 6;
   endfunction

endpackage

// File: rtl/conv3x3_adder_tree.sv
// Registered signed sum of nine packed terms, built as a balanced tree.
module conv3x3_adder_tree
   import conv3x3_pkg::*;
#(
   parameter int IN_W  = 11,
   parameter int OUT_W = 12
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_en,
   input  logic [N_TAPS*IN_W-1:0]     i_terms,
   output logic signed [OUT_W-1:0]    o_sum
);

   logic signed [OUT_W-1:0] ext  [N_TAPS];
   logic signed [OUT_W-1:0] lvl1 [4];
   logic signed [OUT_W-1:0] lvl2 [2];
   logic signed [OUT_W-1:0] sum_d;

   always_comb begin
      for (int k = 0; k < N_TAPS; k++) begin
         ext[k] = OUT_W'(signed'(i_terms[IN_W*k +: IN_W]));
      end
      for (int k = 0; k < 4; k++) begin
         lvl1[k] = ext[2*k] + ext[2*k+1];
      end
      lvl2[0] = lvl1[0] + lvl1[1];
      lvl2[1] = lvl1[2] + lvl1[3];
      sum_d   = lvl2[0] + lvl2[1] + ext[8];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_sum <= '0;
      end else if (i_en) begin
         o_sum <= sum_d;
      end
   end

endmodule

// File: rtl/conv3x3_edge_filter.sv
// Four-stage 3x3 gradient edge filter: multiply, sum, magnitude, output.
// Each beat carries its own kernel/mode/threshold through the pipeline.
module conv3x3_edge_filter
   import conv3x3_pkg::*;
#(
   parameter int P_PIXEL_WIDTH     = 8,
   parameter int P_THRESHOLD_WIDTH = 2 * P_PIXEL_WIDTH + 6,
   parameter int P_THRESHOLD_RESET = 5000
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_valid,
   input  logic [9*P_PIXEL_WIDTH-1:0]     i_data,
   output logic                           o_ready,
   input  logic                           i_kernel_sel,
   input  logic                           i_out_mode,
   input  logic [P_THRESHOLD_WIDTH-1:0]   i_threshold,
   input  logic                           i_ready,
   output logic [P_PIXEL_WIDTH-1:0]       o_data,
   output logic                           o_valid
);

   localparam int W  = P_PIXEL_WIDTH;
   localparam int PW = prod_width(W);
   localparam int SW = sum_width(W);
   localparam int QW = sq_width(W);
   localparam int CW = (QW > P_THRESHOLD_WIDTH) ? QW : P_THRESHOLD_WIDTH;

   if (P_PIXEL_WIDTH < 4 || P_PIXEL_WIDTH > 12) begin : g_bad_width
      $error("conv3x3_edge_filter: P_PIXEL_WIDTH must be 4..12");
   end
   if (P_THRESHOLD_RESET < 0 ||
       longint'(P_THRESHOLD_RESET) >= (longint'(1) << P_THRESHOLD_WIDTH)) begin : g_bad_thr
      $error("conv3x3_edge_filter: P_THRESHOLD_RESET does not fit P_THRESHOLD_WIDTH");
   end

   // Handshake: a beat moves on both ports only when valid && ready at a
   // rising edge. The whole pipe advances together when the output slot is
   // empty or being taken, so o_ready is combinational from i_ready.
   logic en;
   assign en      = !o_valid || i_ready;
   assign o_ready = en;

   // S1: per-tap products for both axes
   logic signed [PW-1:0]       pix_e [N_TAPS];
   logic signed [PW-1:0]       cx_e  [N_TAPS];
   logic signed [PW-1:0]       cy_e  [N_TAPS];
   logic [N_TAPS*PW-1:0]       prod_x_d, prod_y_d, prod_x_q, prod_y_q;
   logic                       prewitt;

   assign prewitt = (kernel_e'(i_kernel_sel) == KERNEL_PREWITT);

   always_comb begin
      prod_x_d = '0;
      prod_y_d = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         pix_e[k] = signed'(PW'(i_data[W*k +: W]));
         cx_e[k]  = PW'(prewitt ? PREWITT_X[k] : SOBEL_X[k]);
         cy_e[k]  = PW'(prewitt ? PREWITT_Y[k] : SOBEL_Y[k]);
         prod_x_d[PW*k +: PW] = cx_e[k] * pix_e[k];
         prod_y_d[PW*k +: PW] = cy_e[k] * pix_e[k];
      end
   end

   logic                          v1, v2, v3;
   out_mode_e                     mode1, mode2, mode3;
   logic [P_THRESHOLD_WIDTH-1:0]  thr1, thr2, thr3;

   // S2: registered sums, one tree per axis
   logic signed [SW-1:0] gx, gy;

   conv3x3_adder_tree #(.IN_W(PW), .OUT_W(SW)) u_tree_x (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (en),
      .i_terms (prod_x_q),
      .o_sum   (gx)
   );

   conv3x3_adder_tree #(.IN_W(PW), .OUT_W(SW)) u_tree_y (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (en),
      .i_terms (prod_y_q),
      .o_sum   (gy)
   );

   // S3: squared magnitude for the threshold path, L1 for the magnitude path
   logic signed [QW-1:0] gx_e, gy_e;
   logic [SW-1:0]        ax, ay;
   logic [QW-1:0]        sq_d, sq_q;
   logic [SW-1:0]        l1_d, l1_q;

   always_comb begin
      gx_e = QW'(gx);
      gy_e = QW'(gy);
      sq_d = gx_e * gx_e + gy_e * gy_e;
      ax   = gx[SW-1] ? -gx : gx;
      ay   = gy[SW-1] ? -gy : gy;
      l1_d = ax + ay;
   end

   // S4: final pixel selection
   logic [W-1:0] out_d;

   always_comb begin
      out_d = '0;
      if (mode3 == OUT_MAGNITUDE) begin
         out_d = (|l1_q[SW-1:W]) ? '1 : l1_q[W-1:0];
      end else if (CW'(sq_q) > CW'(thr3)) begin
         out_d = '1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         v3       <= 1'b0;
         o_valid  <= 1'b0;
         prod_x_q <= '0;
         prod_y_q <= '0;
         mode1    <= OUT_BINARY;
         mode2    <= OUT_BINARY;
         mode3    <= OUT_BINARY;
         thr1     <= '0;
         thr2     <= '0;
         thr3     <= '0;
         sq_q     <= '0;
         l1_q     <= '0;
         o_data   <= '0;
      end else if (en) begin
         v1       <= i_valid;
         prod_x_q <= prod_x_d;
         prod_y_q <= prod_y_d;
         mode1    <= out_mode_e'(i_out_mode);
         thr1     <= i_threshold;
         v2       <= v1;
         mode2    <= mode1;
         thr2     <= thr1;
         v3       <= v2;
         mode3    <= mode2;
         thr3     <= thr2;
         sq_q     <= sq_d;
         l1_q     <= l1_d;
         o_valid  <= v3;
         o_data   <= out_d;
      end
   end

endmodule

// File: tb/tb_conv3x3_edge_filter.sv
// Directed bench for conv3x3_edge_filter: driver pushes hand-computed results
// into a queue, an independent monitor pops and compares on each output beat.
module tb_conv3x3_edge_filter;

   localparam int W  = 8;
   localparam int TW = 2 * W + 6;
   localparam int DW = 9 * W;

   logic           i_clk = 1'b0;
   logic           i_reset;
   logic           i_valid;
   logic [DW-1:0]  i_data;
   logic           o_ready;
   logic           i_kernel_sel;
   logic           i_out_mode;
   logic [TW-1:0]  i_threshold;
   logic           i_ready;
   logic [W-1:0]   o_data;
   logic           o_valid;

   conv3x3_edge_filter #(.P_PIXEL_WIDTH(W)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .o_ready      (o_ready),
      .i_kernel_sel (i_kernel_sel),
      .i_out_mode   (i_out_mode),
      .i_threshold  (i_threshold),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_valid      (o_valid)
   );

   // clock / cycle counter
   always #5 i_clk = ~i_clk;
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // scoreboard
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];
   int           lat_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] win_px(input int k, input logic [W-1:0] v);
      logic [DW-1:0] w = '0;
      w[W*k +: W] = v;
      return w;
   endfunction

   function automatic logic [DW-1:0] win_uniform(input logic [W-1:0] v);
      logic [DW-1:0] w = '0;
      for (int k = 0; k < 9; k++) w[W*k +: W] = v;
      return w;
   endfunction

   // driver tasks
   task automatic send(input logic [DW-1:0] d, input logic ks, input logic om,
                       input logic [TW-1:0] thr, input logic [W-1:0] exp, input bit chk_lat);
      int guard = 0;
      @(negedge i_clk);
      i_valid      = 1'b1;
      i_data       = d;
      i_kernel_sel = ks;
      i_out_mode   = om;
      i_threshold  = thr;
      #1;
      while (!o_ready && guard < 100) begin
         @(negedge i_clk);
         #1;
         guard++;
      end
      if (!o_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: o_ready=0, required 1 within 100 cycles");
      end else begin
         exp_q.push_back(exp);
         lat_q.push_back(chk_lat ? cyc : -1);
         @(posedge i_clk);
      end
   endtask

   task automatic idle();
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge i_clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
      end
   endtask

   // monitor
   initial begin : monitor
      logic [W-1:0] held;
      logic [W-1:0] e;
      int           l;
      bit           stalled;
      held    = '0;
      stalled = 1'b0;
      forever begin
         @(negedge i_clk);
         #2;
         if (i_reset) begin
            stalled = 1'b0;
            continue;
         end
         check("o_ready", {31'd0, o_ready}, {31'd0, !(o_valid && !i_ready)});
         if (stalled) begin
            check("stall_valid", {31'd0, o_valid}, 32'd1);
            check("stall_data", {24'd0, o_data}, {24'd0, held});
         end
         stalled = o_valid && !i_ready;
         held    = o_data;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got 0x%0h, required no output", o_data);
            end else begin
               e = exp_q.pop_front();
               l = lat_q.pop_front();
               check("o_data", {24'd0, o_data}, {24'd0, e});
               if (l >= 0) check("latency", cyc - l, 32'd4);
            end
         end
      end
   end

   // stimulus
   logic [DW-1:0] edge_win;

   initial begin : stim
      edge_win     = win_px(2, 8'd255) | win_px(5, 8'd255) | win_px(8, 8'd255);
      i_reset      = 1'b1;
      i_valid      = 1'b0;
      i_data       = '0;
      i_kernel_sel = 1'b0;
      i_out_mode   = 1'b0;
      i_threshold  = 22'd5000;
      i_ready      = 1'b1;
      #1;
      check("reset_o_valid", {31'd0, o_valid}, 32'd0);
      check("reset_o_data", {24'd0, o_data}, 32'd0);
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      check("release_o_ready", {31'd0, o_ready}, 32'd1);

      // Sobel edge: gx=-1020, sq=1040400 > 5000
      send(edge_win, 1'b0, 1'b0, 22'd5000, 8'hFF, 1'b1);
      idle();
      drain();

      // uniform window: zero gradient in both modes
      send(win_uniform(8'd100), 1'b0, 1'b0, 22'd5000, 8'h00, 1'b1);
      send(win_uniform(8'd100), 1'b0, 1'b1, 22'd5000, 8'h00, 1'b1);
      // Prewitt edge: sq=585225, strict compare
      send(edge_win, 1'b1, 1'b0, 22'd585225, 8'h00, 1'b1);
      send(edge_win, 1'b1, 1'b0, 22'd585224, 8'hFF, 1'b1);
      // Sobel magnitude: p2=10 -> 20; edge saturates
      send(win_px(2, 8'd10), 1'b0, 1'b1, 22'd5000, 8'd20, 1'b1);
      send(edge_win, 1'b0, 1'b1, 22'd5000, 8'hFF, 1'b1);
      idle();
      drain();

      // back-to-back stream with a 3-cycle output stall
      fork
         begin
            send(win_px(2, 8'd10), 1'b0, 1'b1, 22'd5000,    8'd20,  1'b0);
            send(win_px(3, 8'd10), 1'b1, 1'b1, 22'd5000,    8'd10,  1'b0);
            send(edge_win,         1'b0, 1'b0, 22'd5000,    8'hFF,  1'b0);
            send(edge_win,         1'b1, 1'b0, 22'd585225,  8'h00,  1'b0);
            send(win_px(3, 8'd10), 1'b0, 1'b1, 22'd5000,    8'd20,  1'b0);
            send(edge_win,         1'b1, 1'b1, 22'd5000,    8'hFF,  1'b0);
            send(edge_win,         1'b0, 1'b0, 22'd1040400, 8'h00,  1'b0);
            send(edge_win,         1'b1, 1'b0, 22'd585224,  8'hFF,  1'b0);
            idle();
         end
         begin
            repeat (5) @(negedge i_clk);
            i_ready = 1'b0;
            repeat (3) @(negedge i_clk);
            i_ready = 1'b1;
         end
      join
      drain();

      // asynchronous reset with three beats held in the pipe
      @(negedge i_clk);
      i_ready = 1'b0;
      send(edge_win,         1'b0, 1'b0, 22'd5000, 8'hFF, 1'b0);
      send(win_px(2, 8'd10), 1'b0, 1'b1, 22'd5000, 8'd20, 1'b0);
      send(edge_win,         1'b1, 1'b1, 22'd5000, 8'hFF, 1'b0);
      idle();
      repeat (2) @(negedge i_clk);
      #1;
      check("inflight_valid", {31'd0, o_valid}, 32'd1);
      i_reset = 1'b1;
      #1;
      check("async_reset_valid", {31'd0, o_valid}, 32'd0);
      check("async_reset_data", {24'd0, o_data}, 32'd0);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(negedge i_clk);
      i_ready = 1'b1;
      i_reset = 1'b0;
      #1;
      check("post_reset_ready", {31'd0, o_ready}, 32'd1);
      repeat (6) begin
         @(negedge i_clk);
         #1;
         check("post_reset_idle", {31'd0, o_valid}, 32'd0);
      end
      send(win_px(3, 8'd10), 1'b0, 1'b1, 22'd5000, 8'd20, 1'b1);
      idle();
      drain();
      repeat (3) @(negedge i_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
